ghost_release_scheduler: RTL and testbench

GHOST_RELEASE_SCHEDULER -- requirements
Module: ghost_release_scheduler

---
 rtl/ghost_release_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ghost_release_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ghost_release_scheduler.sv
// Ghost release scheduler: staggers ghost enables on frame ticks, freezes all
// ghosts for a fixed number of frames after a hit, and tracks a score-driven speed tier.
module ghost_release_scheduler #(
    parameter int RELEASE_FRAMES = 120,
    parameter int FREEZE_FRAMES  = 90,
    parameter int TIER_SHIFT     = 4,
    parameter int MAX_TIER       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_en,
    input  logic        frame_tick,
    input  logic        collision,
    input  logic [13:0] score,
    output logic [2:0]  ghost_en,
    output logic        ghost_freeze,
    output logic [2:0]  speed_tier,
    output logic [1:0]  sched_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_FREEZE  = 2'd3
    } state_t;

    localparam logic [9:0] REL_LAST = 10'(RELEASE_FRAMES - 1);
    localparam logic [9:0] FRZ_LAST = 10'(FREEZE_FRAMES - 1);

    state_t      state_q, state_d;
    state_t      saved_q, saved_d;
    logic [2:0]  ghost_en_q, ghost_en_d;
    logic        freeze_q, freeze_d;
    logic [2:0]  tier_q, tier_d;
    logic [9:0]  rel_cnt_q, rel_cnt_d;
    logic [9:0]  frz_cnt_q, frz_cnt_d;
    logic [13:0] score_shift_s;
    logic [2:0]  tier_cand_s;

    // Saturate on the full-width shifted score so large scores never alias to a low tier.
    always_comb begin
        score_shift_s = score >> TIER_SHIFT;
        if (score_shift_s > 14'(MAX_TIER)) begin
            tier_cand_s = 3'(MAX_TIER);
        end else begin
            tier_cand_s = score_shift_s[2:0];
        end
    end

    // Next-state and next-output computation for the scheduler.
    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        ghost_en_d = ghost_en_q;
        freeze_d   = freeze_q;
        tier_d     = tier_q;
        rel_cnt_d  = rel_cnt_q;
        frz_cnt_d  = frz_cnt_q;

        if ((state_q != ST_IDLE) && frame_tick && (tier_cand_s > tier_q)) begin
            tier_d = tier_cand_s;
        end else begin
            tier_d = tier_q;
        end

        if ((state_q != ST_IDLE) && !game_en) begin
            state_d    = ST_IDLE;
            saved_d    = ST_RELEASE;
            ghost_en_d = 3'b000;
            freeze_d   = 1'b0;
            tier_d     = 3'd0;
            rel_cnt_d  = 10'd0;
            frz_cnt_d  = 10'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (game_en) begin
                        state_d    = ST_RELEASE;
                        ghost_en_d = 3'b001;
                        rel_cnt_d  = 10'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    // A hit outranks a coincident tick: nothing advances this cycle.
                    if (collision) begin
                        state_d   = ST_FREEZE;
                        saved_d   = ST_RELEASE;
                        freeze_d  = 1'b1;
                        frz_cnt_d = 10'd0;
                    end else if (frame_tick) begin
                        if (rel_cnt_q == REL_LAST) begin
                            rel_cnt_d  = 10'd0;
                            ghost_en_d = {ghost_en_q[1:0], 1'b1};
                            if (ghost_en_q[1]) begin
                                state_d = ST_RUN;
                            end else begin
                                state_d = ST_RELEASE;
                            end
                        end else begin
                            rel_cnt_d = rel_cnt_q + 10'd1;
                        end
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RUN: begin
                    if (collision) begin
                        state_d   = ST_FREEZE;
                        saved_d   = ST_RUN;
                        freeze_d  = 1'b1;
                        frz_cnt_d = 10'd0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FREEZE: begin
                    if (frame_tick) begin
                        if (frz_cnt_q == FRZ_LAST) begin
                            state_d   = saved_q;
                            freeze_d  = 1'b0;
                            frz_cnt_d = 10'd0;
                        end else begin
                            frz_cnt_d = frz_cnt_q + 10'd1;
                        end
                    end else begin
                        state_d = ST_FREEZE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    saved_d    = ST_RELEASE;
                    ghost_en_d = 3'b000;
                    freeze_d   = 1'b0;
                    tier_d     = 3'd0;
                    rel_cnt_d  = 10'd0;
                    frz_cnt_d  = 10'd0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            saved_q    <= ST_RELEASE;
            ghost_en_q <= 3'b000;
            freeze_q   <= 1'b0;
            tier_q     <= 3'd0;
            rel_cnt_q  <= 10'd0;
            frz_cnt_q  <= 10'd0;
        end else begin
            state_q    <= state_d;
            saved_q    <= saved_d;
            ghost_en_q <= ghost_en_d;
            freeze_q   <= freeze_d;
            tier_q     <= tier_d;
            rel_cnt_q  <= rel_cnt_d;
            frz_cnt_q  <= frz_cnt_d;
        end
    end

    assign ghost_en     = ghost_en_q;
    assign ghost_freeze = freeze_q;
    assign speed_tier   = tier_q;
    assign sched_state  = state_q;

endmodule

// File: tb/tb_ghost_release_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a frame-counting reference model of the scheduler rules.
module tb_ghost_release_scheduler;

    localparam int RF = 3;
    localparam int FF = 2;
    localparam int TS = 4;
    localparam int MT = 5;

    logic        clk;
    logic        reset;
    logic        game_en;
    logic        frame_tick;
    logic        collision;
    logic [13:0] score;
    logic [2:0]  ghost_en;
    logic        ghost_freeze;
    logic [2:0]  speed_tier;
    logic [1:0]  sched_state;

    int checks = 0;
    int errors = 0;

    // Reference model: phase (0 idle,1 release,2 run,3 freeze), ghosts out, frames counted.
    int  m_phase;
    int  m_ghosts;
    int  m_rel_frames;
    int  m_frz_frames;
    int  m_resume;
    int  m_tier;
    bit  m_frozen;

    ghost_release_scheduler #(
        .RELEASE_FRAMES(RF),
        .FREEZE_FRAMES (FF),
        .TIER_SHIFT    (TS),
        .MAX_TIER      (MT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .game_en     (game_en),
        .frame_tick  (frame_tick),
        .collision   (collision),
        .score       (score),
        .ghost_en    (ghost_en),
        .ghost_freeze(ghost_freeze),
        .speed_tier  (speed_tier),
        .sched_state (sched_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit ge, input bit ft, input bit col, input int sc);
        int cand;
        if (!r) begin
            m_phase = 0; m_ghosts = 0; m_rel_frames = 0; m_frz_frames = 0;
            m_resume = 1; m_tier = 0; m_frozen = 0;
        end else if (m_phase != 0 && !ge) begin
            m_phase = 0; m_ghosts = 0; m_rel_frames = 0; m_frz_frames = 0;
            m_resume = 1; m_tier = 0; m_frozen = 0;
        end else if (m_phase == 0) begin
            if (ge) begin
                m_phase = 1; m_ghosts = 1; m_rel_frames = 0;
            end
        end else begin
            if (ft) begin
                cand = sc / (1 << TS);
                if (cand > MT) cand = MT;
                if (cand > m_tier) m_tier = cand;
            end
            if (m_phase == 3) begin
                if (ft) begin
                    m_frz_frames++;
                    if (m_frz_frames == FF) begin
                        m_phase = m_resume; m_frozen = 0; m_frz_frames = 0;
                    end
                end
            end else if (col) begin
                m_resume = m_phase; m_phase = 3; m_frozen = 1; m_frz_frames = 0;
            end else if (m_phase == 1 && ft) begin
                m_rel_frames++;
                if (m_rel_frames == RF) begin
                    m_rel_frames = 0;
                    m_ghosts++;
                    if (m_ghosts == 3) m_phase = 2;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit ge, input bit ft, input bit col, input int sc);
        reset = r; game_en = ge; frame_tick = ft; collision = col; score = 14'(sc);
        @(posedge clk);
        #1;
        model_step(r, ge, ft, col, sc);
        check_val("ghost_en",    16'(ghost_en),     16'((1 << m_ghosts) - 1));
        check_val("ghost_freeze", 16'(ghost_freeze), 16'(m_frozen));
        check_val("speed_tier",  16'(speed_tier),   16'(m_tier));
        check_val("sched_state", 16'(sched_state),  16'(m_phase));
    endtask

    initial begin
        reset = 1'b0; game_en = 1'b0; frame_tick = 1'b0; collision = 1'b0; score = 14'd0;

        // Reset then staggered release of all three ghosts.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_val("rst_state", 16'(sched_state), 16'd0);
        check_val("rst_ghost", 16'(ghost_en), 16'd0);
        cycle(1, 1, 0, 0, 0);
        check_val("first_release", 16'(ghost_en), 16'd1);
        for (int t = 1; t <= 7; t++) begin
            cycle(1, 1, 1, 0, 0);
            if (t == 3) check_val("tick3_ghost", 16'(ghost_en), 16'd3);
            if (t == 6) check_val("tick6_state", 16'(sched_state), 16'd2);
        end
        check_val("tick7_ghost", 16'(ghost_en), 16'd7);

        // Freeze mid-release preserves the release counter.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        for (int t = 0; t < 4; t++) cycle(1, 1, 1, 0, 0);
        check_val("pre_hit_ghost", 16'(ghost_en), 16'd3);
        cycle(1, 1, 0, 1, 0);
        check_val("hit_state", 16'(sched_state), 16'd3);
        check_val("hit_freeze", 16'(ghost_freeze), 16'd1);
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check_val("unfreeze_state", 16'(sched_state), 16'd1);
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check_val("resume_ghost", 16'(ghost_en), 16'd7);

        // Collision with tick in RUN; re-hit during freeze does not extend it.
        cycle(1, 1, 1, 1, 0);
        check_val("run_hit", 16'(sched_state), 16'd3);
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 0, 1, 0);
        check_val("still_frozen", 16'(sched_state), 16'd3);
        cycle(1, 1, 1, 0, 0);
        check_val("run_resume", 16'(sched_state), 16'd2);

        // Speed tier saturation, monotonicity and clear.
        cycle(1, 1, 1, 0, 14'h3FFF);
        check_val("tier_sat", 16'(speed_tier), 16'd5);
        cycle(1, 1, 1, 0, 20);
        check_val("tier_mono", 16'(speed_tier), 16'd5);
        cycle(1, 0, 0, 0, 20);
        check_val("tier_clear", 16'(speed_tier), 16'd0);

        // Game stop during freeze with a collision, then a fresh release.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);
        check_val("stop_idle", 16'(sched_state), 16'd0);
        check_val("stop_freeze", 16'(ghost_freeze), 16'd0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check_val("restart_hold", 16'(ghost_en), 16'd1);
        cycle(1, 1, 1, 0, 0);
        check_val("restart_rel", 16'(ghost_en), 16'd3);

        // Reset during freeze, then idle ticks with game off.
        cycle(1, 1, 0, 1, 0);
        cycle(0, 1, 1, 0, 0);
        for (int t = 0; t < 4; t++) cycle(1, 0, 1, 0, 200);
        check_val("post_rst_state", 16'(sched_state), 16'd0);
        check_val("post_rst_ghost", 16'(ghost_en), 16'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 16383)) >> $urandom_range(0, 10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
